// File: rtl/mehdi_onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two
// Avalon-MM masters. It issues at most one access per cycle, blocks
// out-of-range accesses at the RAM, and routes read data back to the
// issuing master through a fixed-latency return pipeline.
module mehdi_onchip_mem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 5120,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

  logic                run;
  logic                last_grant;
  logic                req0, req1;
  logic                grant0, grant1, grant_any;
  logic                sel_id, sel_write, in_range;
  logic [ADDR_W-1:0]   sel_address, hold_address;
  logic [BE_W-1:0]     sel_byteenable, hold_byteenable;
  logic [DATA_W-1:0]   sel_writedata, hold_writedata;

  logic [READ_LATENCY-1:0] pipe_vld, pipe_id, pipe_oor;
  logic                    out_vld, out_id, out_oor;
  logic [DATA_W-1:0]       ret_data;

  // Requests are ignored until the first clock after reset release, which
  // keeps waitrequest high and the RAM disabled throughout reset.
  assign req0 = run & (m0_read | m0_write);
  assign req1 = run & (m1_read | m1_write);

  // last_grant = 1 means m1 was served last, so m0 wins the next tie.
  assign grant0    = req0 & (~req1 | last_grant);
  assign grant1    = req1 & (~req0 | ~last_grant);
  assign grant_any = grant0 | grant1;
  assign sel_id    = grant1;

  // Select the granted master's command; write wins when read and write are both set.
  always_comb begin
    sel_address    = m0_address;
    sel_byteenable = m0_byteenable;
    sel_writedata  = m0_writedata;
    sel_write      = m0_write;
    if (sel_id) begin
      sel_address    = m1_address;
      sel_byteenable = m1_byteenable;
      sel_writedata  = m1_writedata;
      sel_write      = m1_write;
    end
  end

  assign in_range = {1'b0, sel_address} < DEPTH_LIM;

  assign mem_chipselect = grant_any & in_range;
  assign mem_write      = mem_chipselect & sel_write;
  assign mem_address    = grant_any ? sel_address    : hold_address;
  assign mem_byteenable = grant_any ? sel_byteenable : hold_byteenable;
  assign mem_writedata  = grant_any ? sel_writedata  : hold_writedata;
  assign mem_clken      = run;

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  // Run flag, arbitration history and the RAM drive values held over idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run             <= 1'b0;
      last_grant      <= 1'b1;
      hold_address    <= '0;
      hold_byteenable <= '0;
      hold_writedata  <= '0;
    end else begin
      run <= 1'b1;
      if (grant_any) begin
        last_grant      <= sel_id;
        hold_address    <= sel_address;
        hold_byteenable <= sel_byteenable;
        hold_writedata  <= sel_writedata;
      end
    end
  end

  // Read return pipeline carrying {valid, issuer id, out-of-range} in step with the RAM latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
      pipe_oor <= '0;
    end else begin
      pipe_vld[0] <= grant_any & ~sel_write;
      pipe_id[0]  <= sel_id;
      pipe_oor[0] <= ~in_range;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
        pipe_oor[i] <= pipe_oor[i-1];
      end
    end
  end

  assign out_vld  = pipe_vld[READ_LATENCY-1];
  assign out_id   = pipe_id[READ_LATENCY-1];
  assign out_oor  = pipe_oor[READ_LATENCY-1];
  assign ret_data = out_oor ? '0 : mem_readdata;

  assign m0_readdatavalid = out_vld & ~out_id;
  assign m1_readdatavalid = out_vld & out_id;
  assign m0_readdata      = m0_readdatavalid ? ret_data : '0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : '0;

endmodule

// File: tb/tb_mehdi_onchip_mem_arbiter.sv
// Directed bench for mehdi_onchip_mem_arbiter with a behavioural
// single-port RAM (1-cycle read latency, byte enables) behind it.
module tb_mehdi_onchip_mem_arbiter;

  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = 4'hF, m1_byteenable = 4'hF;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mehdi_onchip_mem_arbiter #(
    .ADDR_W(13), .DATA_W(32), .DEPTH(5120), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  // RAM model: word a is preloaded with 0x5A000000 + a on the first edge (during reset).
  logic [31:0] ram [0:5119];
  logic        ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 5120; i++) ram[i] <= 32'h5A00_0000 + i;
      ram_loaded <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_read = 1'b1;
    m0_address = 13'h010;
    repeat (3) @(negedge clk);
    total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_wait0: got %b want 1", m0_waitrequest); end
    total++; if (mem_chipselect !== 1'b0) begin bad++; $display("FAIL reset_cs: got %b want 0", mem_chipselect); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", mem_write); end
    total++; if (mem_clken !== 1'b0) begin bad++; $display("FAIL reset_clken: got %b want 0", mem_clken); end
    total++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin bad++; $display("FAIL reset_rdv: got %b want 00", {m0_readdatavalid, m1_readdatavalid}); end
    next_cycle();
    reset_n = 1'b1;
    m0_read = 1'b0;
    next_cycle();
    @(negedge clk);
    total++; if (mem_clken !== 1'b1) begin bad++; $display("FAIL run_clken: got %b want 1", mem_clken); end
    next_cycle();
  endtask

  task automatic test_write_read();
    int lat;
    int pulses;
    logic [31:0] data;
    m0_write = 1'b1; m0_address = 13'h010; m0_writedata = 32'hA5A5_1234; m0_byteenable = 4'hF;
    @(negedge clk);
    total++; if (m0_waitrequest !== 1'b0) begin bad++; $display("FAIL wr_wait: got %b want 0", m0_waitrequest); end
    total++; if ({mem_chipselect, mem_write} !== 2'b11) begin bad++; $display("FAIL wr_cs_we: got %b want 11", {mem_chipselect, mem_write}); end
    total++; if (mem_address !== 13'h010) begin bad++; $display("FAIL wr_addr: got %h want 010", mem_address); end
    total++; if (mem_writedata !== 32'hA5A5_1234) begin bad++; $display("FAIL wr_data: got %h want a5a51234", mem_writedata); end
    next_cycle();
    m0_write = 1'b0; m0_read = 1'b1;
    @(negedge clk);
    total++; if ({m0_waitrequest, mem_chipselect, mem_write} !== 3'b010) begin bad++; $display("FAIL rd_issue: got %b want 010", {m0_waitrequest, mem_chipselect, mem_write}); end
    total++; if (m0_readdatavalid !== 1'b0) begin bad++; $display("FAIL rd_early: got %b want 0", m0_readdatavalid); end
    next_cycle();
    m0_read = 1'b0;
    lat = 0; pulses = 0; data = '0;
    for (int k = 1; k <= RL + 3; k++) begin
      @(negedge clk);
      if (m0_readdatavalid === 1'b1) begin
        pulses++;
        if (lat == 0) begin lat = k; data = m0_readdata; end
      end
      next_cycle();
    end
    total++; if (lat != RL) begin bad++; $display("FAIL rd_latency: got %0d want %0d", lat, RL); end
    total++; if (pulses != 1) begin bad++; $display("FAIL rd_pulses: got %0d want 1", pulses); end
    total++; if (data !== 32'hA5A5_1234) begin bad++; $display("FAIL rd_data: got %h want a5a51234", data); end
  endtask

  task automatic test_byte_enable();
    m1_write = 1'b1; m1_address = 13'h100; m1_writedata = 32'h1111_1111; m1_byteenable = 4'hF;
    next_cycle();
    m1_writedata = 32'h0000_FF00; m1_byteenable = 4'b0010;
    @(negedge clk);
    total++; if (m1_waitrequest !== 1'b0) begin bad++; $display("FAIL be_wait: got %b want 0", m1_waitrequest); end
    total++; if (mem_byteenable !== 4'b0010) begin bad++; $display("FAIL be_mem: got %b want 0010", mem_byteenable); end
    next_cycle();
    m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 4'hF;
    next_cycle();
    m1_read = 1'b0;
    @(negedge clk);
    total++; if (m1_readdatavalid !== 1'b1) begin bad++; $display("FAIL be_rdv: got %b want 1", m1_readdatavalid); end
    total++; if (m1_readdata !== 32'h1111_FF11) begin bad++; $display("FAIL be_data: got %h want 1111ff11", m1_readdata); end
    total++; if ({m0_readdatavalid, m0_readdata} !== 33'h0) begin bad++; $display("FAIL be_m0_quiet: got %b/%h want 0/0", m0_readdatavalid, m0_readdata); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [12:0] a0, a1;
    int n0, n1;
    logic w0, w1;
    a0 = 13'h200; a1 = 13'h204; n0 = 0; n1 = 0;
    for (int c = 0; c < 12; c++) begin
      m0_read = (c < 8); m1_read = (c < 8);
      m0_address = a0; m1_address = a1;
      @(negedge clk);
      w0 = m0_waitrequest; w1 = m1_waitrequest;
      if (c < 8) begin
        total++; if ({w0, w1} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_grant c=%0d: got wait=%b want %b", c, {w0, w1}, (c % 2 == 0) ? 2'b01 : 2'b10); end
      end
      if (c >= 1 && c <= 8) begin
        total++; if ((m0_readdatavalid ^ m1_readdatavalid) !== 1'b1) begin bad++; $display("FAIL rr_stream c=%0d: got rdv=%b%b want one", c, m0_readdatavalid, m1_readdatavalid); end
      end
      if (m0_readdatavalid === 1'b1) begin
        total++; if (m0_readdata !== 32'h5A00_0200 + n0) begin bad++; $display("FAIL rr_m0_data: got %h want %h", m0_readdata, 32'h5A00_0200 + n0); end
        n0++;
      end
      if (m1_readdatavalid === 1'b1) begin
        total++; if (m1_readdata !== 32'h5A00_0204 + n1) begin bad++; $display("FAIL rr_m1_data: got %h want %h", m1_readdata, 32'h5A00_0204 + n1); end
        n1++;
      end
      next_cycle();
      if (c < 8 && w0 === 1'b0) a0++;
      if (c < 8 && w1 === 1'b0) a1++;
    end
    total++; if (n0 != 4) begin bad++; $display("FAIL rr_m0_count: got %0d want 4", n0); end
    total++; if (n1 != 4) begin bad++; $display("FAIL rr_m1_count: got %0d want 4", n1); end
  endtask

  task automatic test_out_of_range();
    m0_write = 1'b1; m0_address = 13'd5120; m0_writedata = 32'hDEAD_BEEF; m0_byteenable = 4'hF;
    @(negedge clk);
    total++; if ({m0_waitrequest, mem_chipselect, mem_write} !== 3'b000) begin bad++; $display("FAIL oor_wr: got %b want 000", {m0_waitrequest, mem_chipselect, mem_write}); end
    next_cycle();
    m0_write = 1'b0; m0_read = 1'b1;
    @(negedge clk);
    total++; if ({m0_waitrequest, mem_chipselect} !== 2'b00) begin bad++; $display("FAIL oor_rd: got %b want 00", {m0_waitrequest, mem_chipselect}); end
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    total++; if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL oor_data: got %b/%h want 1/0", m0_readdatavalid, m0_readdata); end
    next_cycle();
    m0_read = 1'b1; m0_address = 13'd0;
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    total++; if (m0_readdata !== 32'h5A00_0000) begin bad++; $display("FAIL oor_word0: got %h want 5a000000", m0_readdata); end
    next_cycle();
    m0_read = 1'b1; m0_address = 13'd5119;
    @(negedge clk);
    total++; if (mem_chipselect !== 1'b1) begin bad++; $display("FAIL last_word_cs: got %b want 1", mem_chipselect); end
    next_cycle();
    m0_read = 1'b0;
    @(negedge clk);
    total++; if (m0_readdata !== 32'h5A00_13FF) begin bad++; $display("FAIL last_word_data: got %h want 5a0013ff", m0_readdata); end
    next_cycle();
  endtask

  task automatic test_reset_inflight();
    int seen;
    logic got, w0, w1;
    m0_read = 1'b1; m0_address = 13'h300;
    next_cycle();
    reset_n = 1'b0; m0_read = 1'b0;
    @(negedge clk);
    total++; if (m0_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_pulse_wait: got %b want 1", m0_waitrequest); end
    next_cycle();
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m0_readdatavalid === 1'b1 || m1_readdatavalid === 1'b1) seen++;
      next_cycle();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_dropped: got %0d pulses want 0", seen); end
    m0_read = 1'b1; m1_read = 1'b1; m1_address = 13'h301;
    got = 1'b0; w0 = 1'b1; w1 = 1'b1;
    for (int k = 0; k < 4 && !got; k++) begin
      @(negedge clk);
      if (m0_waitrequest === 1'b0 || m1_waitrequest === 1'b0) begin
        got = 1'b1; w0 = m0_waitrequest; w1 = m1_waitrequest;
      end
      next_cycle();
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL rst_tie_timeout: got no grant want grant"); end
    total++; if ({w0, w1} !== 2'b01) begin bad++; $display("FAIL rst_tie: got wait=%b want 01", {w0, w1}); end
    m0_read = 1'b0; m1_read = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_round_robin();
    test_out_of_range();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
